mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning data and address width.
REQ-002 The block SHALL have parameter MAX_BURST, default 8, meaning the most consecutive m1 grants allowed while m1 holds lock; legal range 1..255.
REQ-003 The block SHALL have these ports, one per line:
 clk_i  in  1  clock; all state changes on rising edge
 rst_i  in  1  asynchronous, active-low reset
 m0_req_i  in  1  core LSU request; held until granted
 m0_we_i  in  1  core write enable
 m0_mask_i  in  4  core byte mask
 m0_addr_i  in  DW  core address
 m0_wdata_i  in  DW  core write data
 m0_gnt_o  out  1  core access performed this cycle
 m0_rvalid_o  out  1  core read data valid
 m0_rdata_o  out  DW  core read data
 m1_req_i, m1_we_i, m1_mask_i, m1_addr_i, m1_wdata_i  in  1/1/4/DW/DW  debug/loader port, same meaning as m0
 m1_lock_i  in  1  m1 requests a locked burst
 m1_gnt_o, m1_rvalid_o, m1_rdata_o  out  1/1/DW  same meaning as m0
 mem_cs_o  out  1  data memory select, active-low
 mem_we_o  out  1  data memory write enable
 mem_mask_o  out  4  data memory byte mask
 mem_addr_o  out  DW  data memory address
 mem_wdata_o  out  DW  data memory write data
 mem_rdata_i  in  DW  data memory combinational read data
 stall_o  out  1  core stall = m0_req_i & ~m0_gnt_o

Function
REQ-004 The block SHALL grant at most one master per cycle; gnt_o is combinational from the req inputs and registered state, and the granted master's fields drive mem_* in the same cycle.
REQ-005 When no master is granted, mem_cs_o SHALL be 1, mem_we_o 0, and mem_mask_o/addr/wdata 0.
REQ-006 When exactly one master requests and the FSM is not in LOCK1, that master SHALL be granted.
REQ-007 When both masters request in IDLE, OWN0 or OWN1, the master not served last SHALL be granted (round-robin); the last_served register resets to 1, so m0 wins the first contention.
REQ-008 FSM states SHALL be IDLE, OWN0, OWN1 and LOCK1; the state after each edge SHALL be OWN0 if m0 was granted, OWN1 if m1 was granted with m1_lock_i=0, LOCK1 if m1 was granted with m1_lock_i=1, and IDLE otherwise.
REQ-009 In LOCK1 with m1_req_i=1 and burst_cnt<MAX_BURST, m1 SHALL be granted regardless of m0.
REQ-010 burst_cnt (8 bits) SHALL load 1 on a m1 grant entering LOCK1, increment on each further locked m1 grant, and clear on any m0 grant or on entering IDLE.
REQ-011 In LOCK1 with burst_cnt==MAX_BURST and m0_req_i=1, m0 SHALL be granted and burst_cnt SHALL clear; if m0 is not requesting, m1 continues and burst_cnt saturates at MAX_BURST.
REQ-012 In LOCK1, if m1_req_i=0 or m1_lock_i=0, arbitration SHALL revert to REQ-006/REQ-007 in that same cycle.
REQ-013 For a granted read (we=0), mem_rdata_i SHALL be registered into that master's rdata_o, and its rvalid_o SHALL pulse high for exactly one cycle on the next cycle (latency 1).
REQ-014 rdata_o SHALL hold its value until the next read completion for that master; writes SHALL NOT assert rvalid_o.
REQ-015 Back-to-back grants SHALL be sustained at one access per cycle, with no idle cycle between masters.

Reset
REQ-016 While rst_i=0, the block SHALL be in IDLE with last_served=1, burst_cnt=0, rvalid_o=0 and rdata_o=0 for both masters.
REQ-017 Reset assertion mid-burst SHALL abandon the burst immediately, and no rvalid_o SHALL be produced for an access granted in the cycle reset asserts.
REQ-018 gnt_o SHALL be 0 while rst_i=0.

Structure
REQ-019 The FSM state enum and the MEM_CS_ACTIVE constant (1'b0) SHALL be placed in a shared package, riscv_pkg.
REQ-020 The block SHALL contain one sub-module, rr_grant, a two-requester round-robin grant with a last_served register; the lock, burst and read-return logic SHALL remain in mem_arbiter.

Verification
REQ-021 The bench SHALL cover a lone m0 read of addr 0x10 with mem_rdata_i=0xDEADBEEF -> m0_gnt_o=1 the same cycle, m0_rvalid_o=1 with m0_rdata_o=0xDEADBEEF the next cycle, stall_o=0.
REQ-022 The bench SHALL cover both masters requesting continuously for 4 cycles with no lock -> grants m0,m1,m0,m1 and stall_o=1 on cycles 2 and 4.
REQ-023 The bench SHALL cover m1_lock_i=1 with MAX_BURST=3 and both masters requesting -> grants m1,m1,m1,m0 with burst_cnt 1,2,3,0.
REQ-024 The bench SHALL cover m1 dropping m1_lock_i after 2 locked grants while m0 requests -> m0 granted that same cycle.
REQ-025 The bench SHALL cover an m1 write of 0x5A to addr 0x40 with mask 0001 -> mem_cs_o=0, mem_we_o=1, mem_mask_o=0001, and no m1_rvalid_o.
REQ-026 The bench SHALL cover rst_i pulled low during a locked burst -> all gnt_o and rvalid_o go to 0 immediately, and after release, contention grants m0 first.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the data-memory arbiter.
package riscv_pkg;

   typedef enum logic [1:0] {
      IDLE,
      OWN0,
      OWN1,
      LOCK1
   } arb_state_e;

   localparam logic MEM_CS_ACTIVE = 1'b0;

endpackage

// File: rtl/rr_grant.sv
// rr_grant: two-requester round-robin grant; last_served favours m0 out of reset.
module rr_grant (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] req_i,
   input  logic       upd_i,
   input  logic       upd_id_i,
   output logic [1:0] gnt_o
);

   logic last_served;

   assign gnt_o[0] = req_i[0] & (~req_i[1] | last_served);
   assign gnt_o[1] = req_i[1] & (~req_i[0] | ~last_served);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) last_served <= 1'b1;
      else if (upd_i) last_served <= upd_id_i;
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master data-memory arbiter with m1 locked bursts and
// one-cycle registered read return per master.
module mem_arbiter
   import riscv_pkg::*;
#(
   parameter int DW        = 32,
   parameter int MAX_BURST = 8
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          m0_req_i,
   input  logic          m0_we_i,
   input  logic [3:0]    m0_mask_i,
   input  logic [DW-1:0] m0_addr_i,
   input  logic [DW-1:0] m0_wdata_i,
   output logic          m0_gnt_o,
   output logic          m0_rvalid_o,
   output logic [DW-1:0] m0_rdata_o,
   input  logic          m1_req_i,
   input  logic          m1_we_i,
   input  logic [3:0]    m1_mask_i,
   input  logic [DW-1:0] m1_addr_i,
   input  logic [DW-1:0] m1_wdata_i,
   input  logic          m1_lock_i,
   output logic          m1_gnt_o,
   output logic          m1_rvalid_o,
   output logic [DW-1:0] m1_rdata_o,
   output logic          mem_cs_o,
   output logic          mem_we_o,
   output logic [3:0]    mem_mask_o,
   output logic [DW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wdata_o,
   input  logic [DW-1:0] mem_rdata_i,
   output logic          stall_o
);

   localparam logic [7:0] MAX_B = 8'(MAX_BURST);

   arb_state_e state, state_nxt;
   logic [7:0] burst_cnt, burst_nxt;
   logic [1:0] rr_gnt;
   logic       lock_hold, gnt0, gnt1, rd0, rd1;

   rr_grant u_rr (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .req_i    ({m1_req_i, m0_req_i}),
      .upd_i    (gnt0 | gnt1),
      .upd_id_i (gnt1),
      .gnt_o    (rr_gnt)
   );

   // A live lock overrides round-robin; once the burst limit is hit m0 may cut in.
   always_comb begin
      lock_hold = (state == LOCK1) & m1_req_i & m1_lock_i;
      gnt1      = rst_i & (lock_hold ? ((burst_cnt < MAX_B) | ~m0_req_i) : rr_gnt[1]);
      gnt0      = rst_i & (lock_hold ? ((burst_cnt >= MAX_B) & m0_req_i) : rr_gnt[0]);
      state_nxt = gnt0 ? OWN0 : gnt1 ? (m1_lock_i ? LOCK1 : OWN1) : IDLE;
      burst_nxt = (gnt1 & m1_lock_i)
                ? ((state != LOCK1) ? 8'd1 : (burst_cnt == MAX_B) ? MAX_B : burst_cnt + 8'd1)
                : 8'd0;
   end

   assign m0_gnt_o    = gnt0;
   assign m1_gnt_o    = gnt1;
   assign stall_o     = m0_req_i & ~gnt0;
   assign rd0         = gnt0 & ~m0_we_i;
   assign rd1         = gnt1 & ~m1_we_i;
   assign mem_cs_o    = (gnt0 | gnt1) ? MEM_CS_ACTIVE : ~MEM_CS_ACTIVE;
   assign mem_we_o    = gnt0 ? m0_we_i : gnt1 & m1_we_i;
   assign mem_mask_o  = gnt0 ? m0_mask_i : gnt1 ? m1_mask_i : 4'h0;
   assign mem_addr_o  = gnt0 ? m0_addr_i : gnt1 ? m1_addr_i : '0;
   assign mem_wdata_o = gnt0 ? m0_wdata_i : gnt1 ? m1_wdata_i : '0;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state       <= IDLE;
         burst_cnt   <= 8'd0;
         m0_rvalid_o <= 1'b0;
         m1_rvalid_o <= 1'b0;
         m0_rdata_o  <= '0;
         m1_rdata_o  <= '0;
      end else begin
         state       <= state_nxt;
         burst_cnt   <= burst_nxt;
         m0_rvalid_o <= rd0;
         m1_rvalid_o <= rd1;
         if (rd0) m0_rdata_o <= mem_rdata_i;
         if (rd1) m1_rdata_o <= mem_rdata_i;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven directed bench for mem_arbiter (MAX_BURST=3)
// plus a hand-written reset-during-burst sequence.
module tb_mem_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i, m1_lock_i;
   logic [3:0]  m0_mask_i, m1_mask_i, mem_mask_o;
   logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
   logic        m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
   logic [31:0] m0_rdata_o, m1_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
   logic        mem_cs_o, mem_we_o, stall_o;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk_i = ~clk_i;

   mem_arbiter #(.DW(32), .MAX_BURST(3)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_mask_i(m0_mask_i),
      .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
      .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
      .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_mask_i(m1_mask_i),
      .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i), .m1_lock_i(m1_lock_i),
      .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
      .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o), .mem_mask_o(mem_mask_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
      .stall_o(stall_o)
   );

   // m0 = {req,we}; m1 = {req,we,lock}; ef = {g0,g1,stall,cs,we}; rv = {rv0,rv1}
   typedef struct {
      logic [1:0]  m0;
      logic [7:0]  m0a;
      logic [2:0]  m1;
      logic [7:0]  m1a;
      logic [7:0]  m1d;
      logic [3:0]  m1m;
      logic [31:0] rd;
      logic [4:0]  ef;
      logic [3:0]  mk;
      logic [7:0]  ad;
      logic [7:0]  wd;
      logic [1:0]  rv;
      logic [31:0] rd0;
      logic [31:0] rd1;
      logic [7:0]  bc;
   } vec_t;

   vec_t vecs[21];

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total_cnt++;
      if (a !== e) $display("FAIL %s: got %h expected %h", n, a, e);
      else pass_cnt++;
   endtask

   task automatic drive(input logic [1:0] m0, input logic [7:0] m0a, input logic [2:0] m1,
                        input logic [7:0] m1a, input logic [7:0] m1d, input logic [3:0] m1m,
                        input logic [31:0] rd);
      m0_req_i    = m0[1];
      m0_we_i     = m0[0];
      m0_addr_i   = {24'h0, m0a};
      m0_mask_i   = 4'hF;
      m0_wdata_i  = 32'hA5;
      m1_req_i    = m1[2];
      m1_we_i     = m1[1];
      m1_lock_i   = m1[0];
      m1_addr_i   = {24'h0, m1a};
      m1_wdata_i  = {24'h0, m1d};
      m1_mask_i   = m1m;
      mem_rdata_i = rd;
   endtask

   initial begin
      vecs[0]  = '{2'b00,8'h00,3'b000,8'h00,8'h00,4'h0,32'h0,       5'b00010,4'h0,8'h00,8'h00,2'b00,32'h0,       32'h0,  8'd0};
      vecs[1]  = '{2'b10,8'h10,3'b000,8'h00,8'h00,4'h0,32'hDEADBEEF,5'b10000,4'hF,8'h10,8'hA5,2'b10,32'hDEADBEEF,32'h0,  8'd0};
      vecs[2]  = '{2'b00,8'h00,3'b110,8'h40,8'h5A,4'h1,32'h12345678,5'b01001,4'h1,8'h40,8'h5A,2'b00,32'hDEADBEEF,32'h0,  8'd0};
      vecs[3]  = '{2'b10,8'h20,3'b100,8'h30,8'h00,4'hF,32'hA0,      5'b10000,4'hF,8'h20,8'hA5,2'b10,32'hA0,      32'h0,  8'd0};
      vecs[4]  = '{2'b10,8'h20,3'b100,8'h30,8'h00,4'hF,32'hA1,      5'b01100,4'hF,8'h30,8'h00,2'b01,32'hA0,      32'hA1, 8'd0};
      vecs[5]  = '{2'b10,8'h20,3'b100,8'h30,8'h00,4'hF,32'hA2,      5'b10000,4'hF,8'h20,8'hA5,2'b10,32'hA2,      32'hA1, 8'd0};
      vecs[6]  = '{2'b10,8'h20,3'b100,8'h30,8'h00,4'hF,32'hA3,      5'b01100,4'hF,8'h30,8'h00,2'b01,32'hA2,      32'hA3, 8'd0};
      vecs[7]  = '{2'b11,8'h50,3'b000,8'h00,8'h00,4'h0,32'h0,       5'b10001,4'hF,8'h50,8'hA5,2'b00,32'hA2,      32'hA3, 8'd0};
      vecs[8]  = '{2'b10,8'h20,3'b101,8'h60,8'h00,4'hF,32'hB0,      5'b01100,4'hF,8'h60,8'h00,2'b01,32'hA2,      32'hB0, 8'd1};
      vecs[9]  = '{2'b10,8'h20,3'b101,8'h60,8'h00,4'hF,32'hB1,      5'b01100,4'hF,8'h60,8'h00,2'b01,32'hA2,      32'hB1, 8'd2};
      vecs[10] = '{2'b10,8'h20,3'b101,8'h60,8'h00,4'hF,32'hB2,      5'b01100,4'hF,8'h60,8'h00,2'b01,32'hA2,      32'hB2, 8'd3};
      vecs[11] = '{2'b10,8'h20,3'b101,8'h60,8'h00,4'hF,32'hB3,      5'b10000,4'hF,8'h20,8'hA5,2'b10,32'hB3,      32'hB2, 8'd0};
      vecs[12] = '{2'b10,8'h20,3'b101,8'h70,8'h00,4'hF,32'hC0,      5'b01100,4'hF,8'h70,8'h00,2'b01,32'hB3,      32'hC0, 8'd1};
      vecs[13] = '{2'b10,8'h20,3'b101,8'h70,8'h00,4'hF,32'hC1,      5'b01100,4'hF,8'h70,8'h00,2'b01,32'hB3,      32'hC1, 8'd2};
      vecs[14] = '{2'b10,8'h20,3'b100,8'h70,8'h00,4'hF,32'hC2,      5'b10000,4'hF,8'h20,8'hA5,2'b10,32'hC2,      32'hC1, 8'd0};
      vecs[15] = '{2'b00,8'h00,3'b101,8'h80,8'h00,4'hF,32'hD0,      5'b01000,4'hF,8'h80,8'h00,2'b01,32'hC2,      32'hD0, 8'd1};
      vecs[16] = '{2'b00,8'h00,3'b101,8'h80,8'h00,4'hF,32'hD1,      5'b01000,4'hF,8'h80,8'h00,2'b01,32'hC2,      32'hD1, 8'd2};
      vecs[17] = '{2'b00,8'h00,3'b101,8'h80,8'h00,4'hF,32'hD2,      5'b01000,4'hF,8'h80,8'h00,2'b01,32'hC2,      32'hD2, 8'd3};
      vecs[18] = '{2'b00,8'h00,3'b101,8'h80,8'h00,4'hF,32'hD3,      5'b01000,4'hF,8'h80,8'h00,2'b01,32'hC2,      32'hD3, 8'd3};
      vecs[19] = '{2'b10,8'h20,3'b101,8'h80,8'h00,4'hF,32'hE0,      5'b10000,4'hF,8'h20,8'hA5,2'b10,32'hE0,      32'hD3, 8'd0};
      vecs[20] = '{2'b00,8'h00,3'b000,8'h00,8'h00,4'h0,32'h0,       5'b00010,4'h0,8'h00,8'h00,2'b00,32'hE0,      32'hD3, 8'd0};

      // Reset held with both masters requesting: nothing may be granted.
      drive(2'b10, 8'h20, 3'b100, 8'h30, 8'h00, 4'hF, 32'h99);
      @(negedge clk_i);
      #1;
      chk("rst_gnt0", 32'(m0_gnt_o), 32'd0);
      chk("rst_gnt1", 32'(m1_gnt_o), 32'd0);
      chk("rst_cs", 32'(mem_cs_o), 32'd1);
      chk("rst_rvalid", {30'd0, m0_rvalid_o, m1_rvalid_o}, 32'd0);
      chk("rst_rdata0", m0_rdata_o, 32'd0);
      chk("rst_rdata1", m1_rdata_o, 32'd0);
      chk("rst_burst", 32'(dut.burst_cnt), 32'd0);
      drive(2'b00, 8'h00, 3'b000, 8'h00, 8'h00, 4'h0, 32'h0);
      rst_i = 1'b1;

      for (int i = 0; i < 21; i++) begin
         @(negedge clk_i);
         drive(vecs[i].m0, vecs[i].m0a, vecs[i].m1, vecs[i].m1a, vecs[i].m1d, vecs[i].m1m, vecs[i].rd);
         #1;
         chk($sformatf("v%0d_flags", i), {27'd0, m0_gnt_o, m1_gnt_o, stall_o, mem_cs_o, mem_we_o}, 32'(vecs[i].ef));
         chk($sformatf("v%0d_mask", i), 32'(mem_mask_o), 32'(vecs[i].mk));
         chk($sformatf("v%0d_addr", i), mem_addr_o, {24'h0, vecs[i].ad});
         chk($sformatf("v%0d_wdata", i), mem_wdata_o, {24'h0, vecs[i].wd});
         @(posedge clk_i);
         #1;
         chk($sformatf("v%0d_rvalid", i), {30'd0, m0_rvalid_o, m1_rvalid_o}, 32'(vecs[i].rv));
         chk($sformatf("v%0d_rdata0", i), m0_rdata_o, vecs[i].rd0);
         chk($sformatf("v%0d_rdata1", i), m1_rdata_o, vecs[i].rd1);
         chk($sformatf("v%0d_burst", i), 32'(dut.burst_cnt), 32'(vecs[i].bc));
      end

      // Locked burst interrupted by reset, then contention after release.
      @(negedge clk_i);
      drive(2'b10, 8'h20, 3'b101, 8'h90, 8'h00, 4'hF, 32'hF0);
      #1;
      chk("lk1_gnt1", 32'(m1_gnt_o), 32'd1);
      @(negedge clk_i);
      drive(2'b10, 8'h20, 3'b101, 8'h90, 8'h00, 4'hF, 32'hF1);
      #1;
      chk("lk2_gnt1", 32'(m1_gnt_o), 32'd1);
      chk("lk2_rvalid1", 32'(m1_rvalid_o), 32'd1);
      @(negedge clk_i);
      chk("lk2_burst", 32'(dut.burst_cnt), 32'd2);
      rst_i = 1'b0;
      #1;
      chk("rstb_gnt", {30'd0, m0_gnt_o, m1_gnt_o}, 32'd0);
      chk("rstb_rvalid", {30'd0, m0_rvalid_o, m1_rvalid_o}, 32'd0);
      chk("rstb_cs", 32'(mem_cs_o), 32'd1);
      chk("rstb_burst", 32'(dut.burst_cnt), 32'd0);
      chk("rstb_rdata1", m1_rdata_o, 32'd0);
      @(posedge clk_i);
      #1;
      chk("rstb_rvalid_after_edge", {30'd0, m0_rvalid_o, m1_rvalid_o}, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b1;
      drive(2'b10, 8'h20, 3'b100, 8'h90, 8'h00, 4'hF, 32'hF2);
      #1;
      chk("post_rst_gnt", {30'd0, m0_gnt_o, m1_gnt_o}, 32'd2);
      chk("post_rst_stall", 32'(stall_o), 32'd0);
      @(posedge clk_i);
      #1;
      chk("post_rst_rvalid0", 32'(m0_rvalid_o), 32'd1);
      chk("post_rst_rdata0", m0_rdata_o, 32'hF2);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
